gpr_write_arbiter: RTL
======================

GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive cycles a pending load entry may lose before it is forced through.
REQ-002 Parameter: DEPTH, default 2, number of load-return buffer entries (fixed at 2 in this revision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wb_en  input  1  WB stage requests a GPR write this cycle.
REQ-006 wb_addr  input  5  WB destination register (IR[11:7]).
REQ-007 wb_data  input  32  WB write data.
REQ-008 ld_valid  input  1  late load/multi-cycle result offered.
REQ-009 ld_addr  input  5  load-return destination register.
REQ-010 ld_data  input  32  load-return data.
REQ-011 ld_ready  output  1  buffer can accept an entry this cycle.
REQ-012 gpr_we  output  1  register-file write enable (registered).
REQ-013 gpr_waddr  output  5  register-file write address (registered).
REQ-014 gpr_wdata  output  32  register-file write data (registered).
REQ-015 stall_req  output  1  WB request lost arbitration; pipeline holds WB contents and re-presents next cycle (combinational).
REQ-016 buf_count  output  2  occupied buffer entries (0..2).

Function
REQ-017 ld_ready SHALL be 1 exactly when registered buf_count < 2; a push occurs when ld_valid && ld_ready.
REQ-018 Buffer SHALL be FIFO; a pushed entry becomes eligible for grant the cycle after the push (no bypass).
REQ-019 Grant each cycle: buffer head if buf_count>0 and (wb_en==0 or starve_cnt==STARVE_LIMIT); else WB if wb_en; else none.
REQ-020 stall_req SHALL equal wb_en && (buffer head granted).
REQ-021 starve_cnt SHALL increment (saturating at STARVE_LIMIT) when buf_count>0 and WB is granted, and clear to 0 when the head is popped or the buffer is empty.
REQ-022 Granted request SHALL appear on gpr_we/gpr_waddr/gpr_wdata one cycle later; latency exactly 1 cycle.
REQ-023 Grant with address 0 SHALL be consumed (popped/acknowledged) but drive gpr_we=0 (x0 never written).
REQ-024 No grant: gpr_we=0 next cycle; gpr_waddr/gpr_wdata hold previous values.
REQ-025 Simultaneous push and pop with buf_count==1 SHALL leave buf_count at 1 with the new entry at head next cycle.
REQ-026 Push is impossible at buf_count==2 (ld_ready=0) even if a pop occurs that cycle.
REQ-027 Ordering between a WB write and a buffered write to the same register is grant order; hazard avoidance belongs to issue logic.

Reset
REQ-028 While rst_n==0: buf_count=0, starve_cnt=0, gpr_we=0, gpr_waddr=0, gpr_wdata=0, read/write pointers=0; ld_ready=1 and stall_req=0 follow combinationally.
REQ-029 Reset mid-operation SHALL discard buffered entries without issuing writes; first grant possible on the first edge after rst_n rises.

Structure
REQ-030 Shared package wb_arb_pkg SHALL hold STARVE_LIMIT default, REG_ADDR_W=5, XLEN=32, and the grant-source enum {GNT_NONE, GNT_WB, GNT_LD}.
REQ-031 Buffer SHALL be a sub-module gpr_wr_fifo (2 entries, 37-bit payload, push/pop/count); arbitration and output registers live in the top.

Verification
REQ-032 Reset then wb_en=1, wb_addr=5, wb_data=0xDEADBEEF -> next cycle gpr_we=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF, stall_req=0.
REQ-033 Idle WB, push ld_addr=7/0x11 then ld_addr=8/0x22 on consecutive cycles -> writes r7=0x11, r8=0x22 in order, buf_count returns to 0.
REQ-034 Buffer holds 1 entry, wb_en held 1 with distinct addresses -> WB wins 4 cycles, 5th cycle stall_req=1 and buffer entry written, starve_cnt=0 after.
REQ-035 Fill to 2 entries -> ld_ready=0; offered ld_valid ignored; after one pop ld_ready=1 next cycle.
REQ-036 wb_en=1, wb_addr=0 and buffered ld_addr=0 -> both consumed, gpr_we stays 0.
REQ-037 Assert rst_n=0 with buf_count=2 -> outputs to reset values immediately, no write of buffered data after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the GPR write-port arbiter.
package wb_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned REG_ADDR_W           = 5;
  localparam int unsigned XLEN                 = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LD
  } gnt_src_e;

  // One register-file write request: 37-bit payload.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;

endpackage

// File: rtl/gpr_write_arbiter_if.sv
// Bundle of WB request, load-return and register-file write signals.
interface gpr_write_arbiter_if;

  logic                              wb_en;
  logic [wb_arb_pkg::REG_ADDR_W-1:0] wb_addr;
  logic [wb_arb_pkg::XLEN-1:0]       wb_data;
  logic                              ld_valid;
  logic [wb_arb_pkg::REG_ADDR_W-1:0] ld_addr;
  logic [wb_arb_pkg::XLEN-1:0]       ld_data;
  logic                              ld_ready;
  logic                              gpr_we;
  logic [wb_arb_pkg::REG_ADDR_W-1:0] gpr_waddr;
  logic [wb_arb_pkg::XLEN-1:0]       gpr_wdata;
  logic                              stall_req;
  logic [1:0]                        buf_count;

  modport master (
    output wb_en, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
    input  ld_ready, gpr_we, gpr_waddr, gpr_wdata, stall_req, buf_count
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
    output ld_ready, gpr_we, gpr_waddr, gpr_wdata, stall_req, buf_count
  );

endinterface

// File: rtl/gpr_wr_fifo.sv
// Two-entry FIFO holding late load-return writes until the write port is free.
module gpr_wr_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  wr_req_t    push_data,
  input  logic       pop,
  output wr_req_t    head,
  output logic [1:0] count,
  output logic       full
);

  wr_req_t    mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full    = (count_q == 2'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count_q != 2'd0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Arbitrates the single GPR write port between the WB stage and buffered load returns.
module gpr_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int unsigned DEPTH        = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  gpr_write_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  wr_req_t               head;
  wr_req_t               gnt_req;
  logic [1:0]            count;
  logic                  full, push, pop;
  gnt_src_e              gnt_src;
  logic [CntW-1:0]       starve_q, starve_d;
  logic                  gpr_we_q;
  logic [REG_ADDR_W-1:0] gpr_waddr_q;
  logic [XLEN-1:0]       gpr_wdata_q;

  gpr_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.ld_addr, bus.ld_data}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  always_comb begin
    gnt_src = GNT_NONE;
    if ((count != 2'd0) && (!bus.wb_en || (starve_q == CntW'(STARVE_LIMIT)))) begin
      gnt_src = GNT_LD;
    end else if (bus.wb_en) begin
      gnt_src = GNT_WB;
    end
  end

  always_comb begin
    gnt_req = '0;
    unique case (gnt_src)
      GNT_LD:  gnt_req = head;
      GNT_WB:  gnt_req = {bus.wb_addr, bus.wb_data};
      default: gnt_req = '0;
    endcase
  end

  assign push = bus.ld_valid && !full;
  assign pop  = (gnt_src == GNT_LD);

  // Age only while an entry is waiting and WB takes the port.
  always_comb begin
    starve_d = starve_q;
    if ((count == 2'd0) || pop) begin
      starve_d = '0;
    end else if ((gnt_src == GNT_WB) && (starve_q != CntW'(STARVE_LIMIT))) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      // x0 grants are consumed but never reach the register file.
      gpr_we_q <= (gnt_src != GNT_NONE) && (gnt_req.addr != '0);
      if (gnt_src != GNT_NONE) begin
        gpr_waddr_q <= gnt_req.addr;
        gpr_wdata_q <= gnt_req.data;
      end
    end
  end

  assign bus.ld_ready  = !full;
  assign bus.stall_req = bus.wb_en && (gnt_src == GNT_LD);
  assign bus.buf_count = count;
  assign bus.gpr_we    = gpr_we_q;
  assign bus.gpr_waddr = gpr_waddr_q;
  assign bus.gpr_wdata = gpr_wdata_q;

endmodule
